bus_resolver: RTL and testbench
===============================

# bus_resolver

Parametrised, registered multi-driver bus resolver for board-level top modules. It merges N drivers, each with a value and a per-bit release flag, into one W-bit bus on MCLK. It generalises the hand-written OR-merge/hold expressions used today for VD/VA/ZD/ZA. On top of that merge it adds:
- selectable wired-OR / wired-AND resolution;
- a bus keeper with optional decay to a pull value;
- sticky contention monitoring for debug.

## Interface
Parameters:
- N, 4: number of drivers (≥1).
- W, 16: bus width (≥1).
- MODE, 0: 0 = wired-OR of driven values, 1 = wired-AND of driven values.
- RESET_VAL, {W{1'b0}}: bus value after reset.
- PULL_VAL, {W{1'b1}}: value the bus decays to when fully floating.
- DECAY_CYCLES, 64: consecutive fully-released cycles before decay (≥1, ≤65535).

Ports:
- MCLK  in  1  clock; all state updates on posedge.
- ext_reset  in  1  asynchronous, active-high reset.
- drv_o  in  N*W  driver values; driver k occupies [k*W +: W].
- drv_d  in  N*W  per-bit release; 1 = released (high-Z), 0 = driving.
- clr  in  1  synchronous clear of the contention status.
- bus  out  W  resolved, registered bus.
- bus_driven  out  W  registered; bit = 1 if ≥1 driver drove that bit in the sampled cycle.
- contention  out  1  sticky contention flag.
- cont_count  out  8  count of contention cycles, saturating at 255.
- cont_first_drv  out  max(1,$clog2(N))  lowest driver index involved in the first captured contention.
- cont_first_bit  out  max(1,$clog2(W))  lowest bit index of the first captured contention.

## Operation
- Per bit b, the driven set is {k : drv_d[k*W+b]==0}.
- Non-empty set: next bus[b] = OR (MODE 0) or AND (MODE 1) of drv_o over the set.
- Empty set: bus[b] holds its current value (keeper).
- Decay counter (16-bit):
  - Increments each cycle in which every bit is released.
  - Resets to 0 in any cycle with ≥1 bit driven.
  - At the cycle its value reaches DECAY_CYCLES-1 with the bus still fully released, the whole bus loads PULL_VAL. The counter then saturates and the bus stays at PULL_VAL until driven.
- Contention on bit b: ≥2 drivers in the driven set present differing drv_o values. Detection is evaluated on the same sampled inputs as resolution. The resolved value still follows MODE when contention occurs.
- In a contention cycle:
  - contention is set to 1.
  - cont_count increments, saturating at 255.
  - If contention was 0 before the cycle, cont_first_bit/cont_first_drv capture the lowest offending bit and the lowest driver index driving that bit.
- clr: next contention=0, cont_count=0, capture fields=0.
- clr in the same cycle as a new contention: contention wins. Result is contention=1, cont_count=1, and the capture fields take the new event.

## Timing
- Latency 1 cycle: inputs sampled at edge t appear on bus/bus_driven after edge t.
- Contention outputs update at the same edge as bus.
- Reset (asynchronous, any time, including mid-decay): bus=RESET_VAL, bus_driven=0, decay counter=0, contention=0, cont_count=0, cont_first_drv=0, cont_first_bit=0.
- First edge after reset deassertion resolves normally.
- A single driver re-driving the bus on the cycle decay would fire: the driven value wins and the counter clears.
- Bits partially driven: undriven bits hold. No per-bit decay.

## Configuration
- BUS_RESOLVER_DECAY_EN defined: decay counter and PULL_VAL load as above.
- Not defined: no counter is built, the keeper holds indefinitely, and PULL_VAL and DECAY_CYCLES are ignored.

## Structure
- Package bus_pkg:
  - MODE_WOR=0 and MODE_WAND=1 constants.
  - The cont_count width constant (8) and its saturation value.
  - A clog2-min-1 helper function.
- One sub-module, bus_contention_mon. It takes the per-bit driven masks and values, plus clr, and owns the sticky flag, counter and capture priority encoders.
- The top owns resolution, the keeper and decay.

## Test plan
- N=4, W=16, MODE 0: driver 1 drives 16'h00F0 and driver 2 drives 16'h0F00 on disjoint bits, others released. Required: bus=16'h0FF0 one cycle later, bus_driven=16'h0FF0, contention=0.
- Driver 0 drives 16'h1234 for one cycle, then all drivers release. Required: bus holds 16'h1234. With the macro defined and DECAY_CYCLES=64, bus becomes 16'hFFFF exactly 64 cycles after the first released edge. Without the macro it stays 16'h1234.
- Drivers 2 and 3 both drive bit 5 only, values 1 and 0, for 3 cycles. Required, MODE 0: bus[5]=1. Required in all cases: contention=1, cont_count=3, cont_first_bit=5, cont_first_drv=2.
- Sustained contention for 300 cycles. Required: cont_count saturates at 255. Then clr is pulsed together with a contention on bit 9 by drivers 0 and 1. Required: cont_count=1, cont_first_bit=9, cont_first_drv=0.
- MODE 1: drivers 0 and 1 drive 16'hFF00 and 16'hF0F0. Required: bus=16'hF000.
- ext_reset asserted asynchronously mid-decay (counter at 40). Required: all outputs go to reset values immediately. After release, a full 64-cycle float is required before PULL_VAL loads.

Source files
------------

// File: rtl/bus_resolver_pkg.sv
// Shared constants for the bus resolver: resolution modes, contention counter
// sizing and a width helper for the capture fields.
package bus_pkg;

  localparam int MODE_WOR  = 0;
  localparam int MODE_WAND = 1;

  localparam int                    CONT_CNT_W   = 8;
  localparam logic [CONT_CNT_W-1:0] CONT_CNT_MAX = '1;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bus_resolver_contention_mon.sv
// Sticky contention monitor: flags bits where driven values disagree, counts
// contention cycles and captures the first offending bit and driver.
module bus_contention_mon
  import bus_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                          MCLK,
  input  logic                          ext_reset,
  input  logic [N*W-1:0]                drv_mask,
  input  logic [N*W-1:0]                drv_val,
  input  logic                          clr,
  output logic                          contention,
  output logic [CONT_CNT_W-1:0]         cont_count,
  output logic [clog2_min1(N)-1:0]      cont_first_drv,
  output logic [clog2_min1(W)-1:0]      cont_first_bit
);

  localparam int DRV_W = clog2_min1(N);
  localparam int BIT_W = clog2_min1(W);

  logic [W-1:0]            any_one;
  logic [W-1:0]            any_zero;
  logic [W-1:0]            cont_bits;
  logic [BIT_W-1:0]        hit_bit;
  logic [DRV_W-1:0]        hit_drv;

  logic                    contention_q, contention_d;
  logic [CONT_CNT_W-1:0]   cont_count_q, cont_count_d;
  logic [DRV_W-1:0]        first_drv_q, first_drv_d;
  logic [BIT_W-1:0]        first_bit_q, first_bit_d;

  always_comb begin
    any_one  = '0;
    any_zero = '0;
    for (int k = 0; k < N; k++) begin
      any_one  |= drv_mask[k*W +: W] &  drv_val[k*W +: W];
      any_zero |= drv_mask[k*W +: W] & ~drv_val[k*W +: W];
    end
    cont_bits = any_one & any_zero;
  end

  // Descending scans so the lowest index is the one that sticks.
  always_comb begin
    hit_bit = '0;
    hit_drv = '0;
    for (int b = W - 1; b >= 0; b--) begin
      if (cont_bits[b]) hit_bit = BIT_W'(b);
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (drv_mask[k*W + int'(hit_bit)]) hit_drv = DRV_W'(k);
    end
  end

  always_comb begin
    contention_d = contention_q;
    cont_count_d = cont_count_q;
    first_drv_d  = first_drv_q;
    first_bit_d  = first_bit_q;
    if (clr) begin
      contention_d = 1'b0;
      cont_count_d = '0;
      first_drv_d  = '0;
      first_bit_d  = '0;
    end
    // A new event overrides a simultaneous clear and becomes the first capture.
    if (|cont_bits) begin
      contention_d = 1'b1;
      if (clr)
        cont_count_d = CONT_CNT_W'(1);
      else if (cont_count_q != CONT_CNT_MAX)
        cont_count_d = cont_count_q + CONT_CNT_W'(1);
      if (!contention_q || clr) begin
        first_drv_d = hit_drv;
        first_bit_d = hit_bit;
      end
    end
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      contention_q <= 1'b0;
      cont_count_q <= '0;
      first_drv_q  <= '0;
      first_bit_q  <= '0;
    end else begin
      contention_q <= contention_d;
      cont_count_q <= cont_count_d;
      first_drv_q  <= first_drv_d;
      first_bit_q  <= first_bit_d;
    end
  end

  assign contention     = contention_q;
  assign cont_count     = cont_count_q;
  assign cont_first_drv = first_drv_q;
  assign cont_first_bit = first_bit_q;

endmodule

// File: rtl/bus_resolver.sv
// Registered N-driver bus resolver with keeper; defining BUS_RESOLVER_DECAY_EN
// adds decay of a fully floating bus to PULL_VAL after DECAY_CYCLES cycles.
module bus_resolver
  import bus_pkg::*;
#(
  parameter int           N            = 4,
  parameter int           W            = 16,
  parameter int           MODE         = MODE_WOR,
  parameter logic [W-1:0] RESET_VAL    = '0,
  parameter logic [W-1:0] PULL_VAL     = '1,
  parameter int           DECAY_CYCLES = 64
) (
  input  logic                          MCLK,
  input  logic                          ext_reset,
  input  logic [N*W-1:0]                drv_o,
  input  logic [N*W-1:0]                drv_d,
  input  logic                          clr,
  output logic [W-1:0]                  bus,
  output logic [W-1:0]                  bus_driven,
  output logic                          contention,
  output logic [CONT_CNT_W-1:0]         cont_count,
  output logic [clog2_min1(N)-1:0]      cont_first_drv,
  output logic [clog2_min1(W)-1:0]      cont_first_bit
);

  logic [N*W-1:0] drv_mask;
  logic [W-1:0]   driven_any;
  logic [W-1:0]   or_val;
  logic [W-1:0]   and_val;
  logic [W-1:0]   resolved;
  logic           decay_fire;

  logic [W-1:0]   bus_q, bus_d;
  logic [W-1:0]   bus_driven_q;

  assign drv_mask = ~drv_d;

  always_comb begin
    driven_any = '0;
    or_val     = '0;
    and_val    = '1;
    for (int k = 0; k < N; k++) begin
      driven_any |= drv_mask[k*W +: W];
      or_val     |= drv_mask[k*W +: W] & drv_o[k*W +: W];
      and_val    &= ~drv_mask[k*W +: W] | drv_o[k*W +: W];
    end
    resolved = (MODE == MODE_WAND) ? and_val : or_val;
  end

`ifdef BUS_RESOLVER_DECAY_EN
  localparam logic [15:0] DECAY_LAST = 16'(DECAY_CYCLES - 1);

  logic [15:0] decay_cnt_q, decay_cnt_d;

  // The counter parks at DECAY_LAST so the pull keeps reloading until driven.
  always_comb begin
    decay_cnt_d = decay_cnt_q;
    decay_fire  = 1'b0;
    if (driven_any != '0)
      decay_cnt_d = '0;
    else if (decay_cnt_q == DECAY_LAST)
      decay_fire = 1'b1;
    else
      decay_cnt_d = decay_cnt_q + 16'd1;
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) decay_cnt_q <= '0;
    else           decay_cnt_q <= decay_cnt_d;
  end
`else
  logic unused_decay_cfg;

  assign decay_fire       = 1'b0;
  assign unused_decay_cfg = (DECAY_CYCLES > 0);
`endif

  always_comb begin
    bus_d = (resolved & driven_any) | (bus_q & ~driven_any);
    if (decay_fire) bus_d = PULL_VAL;
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      bus_q        <= RESET_VAL;
      bus_driven_q <= '0;
    end else begin
      bus_q        <= bus_d;
      bus_driven_q <= driven_any;
    end
  end

  assign bus        = bus_q;
  assign bus_driven = bus_driven_q;

  bus_contention_mon #(
    .N(N),
    .W(W)
  ) u_mon (
    .MCLK           (MCLK),
    .ext_reset      (ext_reset),
    .drv_mask       (drv_mask),
    .drv_val        (drv_o),
    .clr            (clr),
    .contention     (contention),
    .cont_count     (cont_count),
    .cont_first_drv (cont_first_drv),
    .cont_first_bit (cont_first_bit)
  );

endmodule

// File: tb/tb_bus_resolver.sv
// Self-checking bench for bus_resolver: a wired-OR and a wired-AND instance
// share stimulus and are compared every cycle against a per-bit reference model.
module tb_bus_resolver;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DECAY = 64;

`ifdef BUS_RESOLVER_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif

  logic           MCLK = 1'b0;
  logic           ext_reset;
  logic [N*W-1:0] drv_o;
  logic [N*W-1:0] drv_d;
  logic           clr;

  logic [W-1:0] bus_or, bus_driven_or, bus_and, bus_driven_and;
  logic         contention_or, contention_and;
  logic [7:0]   count_or, count_and;
  logic [1:0]   first_drv_or, first_drv_and;
  logic [3:0]   first_bit_or, first_bit_and;

  logic [W-1:0] m_bus [2];
  logic [W-1:0] m_driven;
  bit           m_cont;
  int           m_count, m_first_drv, m_first_bit, m_float_run;

  int checks   = 0;
  int failures = 0;

  always #5 MCLK = ~MCLK;

  bus_resolver #(.N(N), .W(W), .MODE(0), .DECAY_CYCLES(DECAY)) dut_or (
    .MCLK(MCLK), .ext_reset(ext_reset), .drv_o(drv_o), .drv_d(drv_d), .clr(clr),
    .bus(bus_or), .bus_driven(bus_driven_or), .contention(contention_or),
    .cont_count(count_or), .cont_first_drv(first_drv_or), .cont_first_bit(first_bit_or)
  );

  bus_resolver #(.N(N), .W(W), .MODE(1), .DECAY_CYCLES(DECAY)) dut_and (
    .MCLK(MCLK), .ext_reset(ext_reset), .drv_o(drv_o), .drv_d(drv_d), .clr(clr),
    .bus(bus_and), .bus_driven(bus_driven_and), .contention(contention_and),
    .cont_count(count_and), .cont_first_drv(first_drv_and), .cont_first_bit(first_bit_and)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [N*W-1:0] placeVal(input int k, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[k*W +: W] = v;
    return r;
  endfunction

  task automatic modelReset();
    m_bus[0]    = '0;
    m_bus[1]    = '0;
    m_driven    = '0;
    m_cont      = 1'b0;
    m_count     = 0;
    m_first_drv = 0;
    m_first_bit = 0;
    m_float_run = 0;
  endtask

  // Per bit: gather which values the driving set presents, then apply the rules.
  task automatic modelStep();
    int cbit = -1;
    logic [W-1:0] mask = '0;
    for (int b = 0; b < W; b++) begin
      bit seen0 = 1'b0;
      bit seen1 = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (drv_d[k*W+b] == 1'b0) begin
          if (drv_o[k*W+b]) seen1 = 1'b1;
          else              seen0 = 1'b1;
        end
      end
      mask[b] = seen0 | seen1;
      if (mask[b]) begin
        m_bus[0][b] = seen1;
        m_bus[1][b] = !seen0;
      end
      if (seen0 && seen1 && cbit < 0) cbit = b;
    end
    m_driven = mask;
    if (mask == '0) begin
      m_float_run++;
      if (DECAY_ON && m_float_run >= DECAY) begin
        m_bus[0] = '1;
        m_bus[1] = '1;
      end
    end else begin
      m_float_run = 0;
    end
    if (cbit >= 0) begin
      if (clr) m_count = 0;
      if (!m_cont || clr) begin
        m_first_bit = cbit;
        m_first_drv = -1;
        for (int k = 0; k < N; k++)
          if (drv_d[k*W+cbit] == 1'b0 && m_first_drv < 0) m_first_drv = k;
      end
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_cont  = 1'b1;
    end else if (clr) begin
      m_cont      = 1'b0;
      m_count     = 0;
      m_first_drv = 0;
      m_first_bit = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".bus_or"},        32'(bus_or),         32'(m_bus[0]));
    checkOutput({tag, ".bus_and"},       32'(bus_and),        32'(m_bus[1]));
    checkOutput({tag, ".driven_or"},     32'(bus_driven_or),  32'(m_driven));
    checkOutput({tag, ".driven_and"},    32'(bus_driven_and), 32'(m_driven));
    checkOutput({tag, ".cont_or"},       32'(contention_or),  32'(m_cont));
    checkOutput({tag, ".cont_and"},      32'(contention_and), 32'(m_cont));
    checkOutput({tag, ".count_or"},      32'(count_or),       32'(m_count));
    checkOutput({tag, ".count_and"},     32'(count_and),      32'(m_count));
    checkOutput({tag, ".first_drv_or"},  32'(first_drv_or),   32'(m_first_drv));
    checkOutput({tag, ".first_drv_and"}, 32'(first_drv_and),  32'(m_first_drv));
    checkOutput({tag, ".first_bit_or"},  32'(first_bit_or),   32'(m_first_bit));
    checkOutput({tag, ".first_bit_and"}, 32'(first_bit_and),  32'(m_first_bit));
  endtask

  task automatic applyStimulus(input string tag, input logic [N*W-1:0] o,
                               input logic [N*W-1:0] d, input logic c);
    drv_o = o;
    drv_d = d;
    clr   = c;
    @(posedge MCLK);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic releaseCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, '0, '1, 1'b0);
  endtask

  task automatic pulseReset();
    #2 ext_reset = 1'b1;
    #1 modelReset();
    checkAll("async_rst");
    checkOutput("async_rst.bus_const", 32'(bus_or), 32'h0);
    @(posedge MCLK);
    #1 ext_reset = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] o, d;
    ext_reset = 1'b1;
    drv_o = '0;
    drv_d = '1;
    clr   = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    #1 ext_reset = 1'b0;

    // Disjoint drivers merge without contention.
    o = placeVal(1, 16'h00F0) | placeVal(2, 16'h0F00);
    d = ~o;
    applyStimulus("disjoint", o, d, 1'b0);
    checkOutput("disjoint.bus_const", 32'(bus_or), 32'h0FF0);
    checkOutput("disjoint.driven_const", 32'(bus_driven_or), 32'h0FF0);
    checkOutput("disjoint.cont_const", 32'(contention_or), 32'h0);

    // Keeper and decay timing.
    applyStimulus("drive1234", placeVal(0, 16'h1234), ~placeVal(0, 16'hFFFF), 1'b0);
    releaseCycles("float", 63);
    checkOutput("float63.bus_const", 32'(bus_or), 32'h1234);
    releaseCycles("float", 1);
    checkOutput("float64.bus_const", 32'(bus_or), DECAY_ON ? 32'hFFFF : 32'h1234);
    releaseCycles("float_sat", 5);

    // Two drivers disagree on bit 5.
    o = placeVal(2, 16'h0020);
    d = ~(placeVal(2, 16'h0020) | placeVal(3, 16'h0020));
    for (int i = 0; i < 3; i++) applyStimulus("cont_b5", o, d, 1'b0);
    checkOutput("cont_b5.bit5_or", 32'(bus_or[5]), 32'h1);
    checkOutput("cont_b5.bit5_and", 32'(bus_and[5]), 32'h0);
    checkOutput("cont_b5.flag_const", 32'(contention_or), 32'h1);
    checkOutput("cont_b5.count_const", 32'(count_or), 32'd3);
    checkOutput("cont_b5.bit_const", 32'(first_bit_or), 32'd5);
    checkOutput("cont_b5.drv_const", 32'(first_drv_or), 32'd2);

    // Saturation, then a clear colliding with a new event.
    for (int i = 0; i < 297; i++) applyStimulus("cont_sat", o, d, 1'b0);
    checkOutput("cont_sat.count_const", 32'(count_or), 32'd255);
    o = placeVal(0, 16'h0200);
    d = ~(placeVal(0, 16'h0200) | placeVal(1, 16'h0200));
    applyStimulus("clr_cont", o, d, 1'b1);
    checkOutput("clr_cont.count_const", 32'(count_or), 32'd1);
    checkOutput("clr_cont.bit_const", 32'(first_bit_or), 32'd9);
    checkOutput("clr_cont.drv_const", 32'(first_drv_or), 32'd0);
    applyStimulus("clr_only", '0, '1, 1'b1);
    checkOutput("clr_only.cont_const", 32'(contention_or), 32'h0);
    checkOutput("clr_only.count_const", 32'(count_or), 32'd0);

    // Wired-AND versus wired-OR on overlapping drivers.
    o = placeVal(0, 16'hFF00) | placeVal(1, 16'hF0F0);
    d = ~(placeVal(0, 16'hFFFF) | placeVal(1, 16'hFFFF));
    applyStimulus("wand", o, d, 1'b0);
    checkOutput("wand.bus_and_const", 32'(bus_and), 32'hF000);
    checkOutput("wand.bus_or_const", 32'(bus_or), 32'hFFF0);

    // Reset in the middle of a float, then a full float is needed again.
    applyStimulus("drive_a5", placeVal(3, 16'hA5A5), ~placeVal(3, 16'hFFFF), 1'b0);
    releaseCycles("prefloat", 40);
    pulseReset();
    releaseCycles("post_rst", 63);
    checkOutput("post_rst63.bus_const", 32'(bus_or), 32'h0);
    releaseCycles("post_rst", 1);
    checkOutput("post_rst64.bus_const", 32'(bus_or), DECAY_ON ? 32'hFFFF : 32'h0);

    // Driving on the edge decay would fire wins and restarts the float.
    applyStimulus("redrive0", placeVal(1, 16'h1111), ~placeVal(1, 16'hFFFF), 1'b0);
    releaseCycles("prefire", 63);
    applyStimulus("redrive", placeVal(0, 16'h5A5A), ~placeVal(0, 16'hFFFF), 1'b0);
    checkOutput("redrive.bus_const", 32'(bus_or), 32'h5A5A);
    releaseCycles("refloat", 63);
    checkOutput("refloat63.bus_const", 32'(bus_or), 32'h5A5A);

    // Randomized traffic with occasional long floats and clears.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        releaseCycles("rand_float", $urandom_range(60, 70));
      end else begin
        o = {$urandom, $urandom};
        if (r < 5) d = '1;
        else       d = {$urandom, $urandom} | {$urandom, $urandom};
        applyStimulus("rand", o, d, ($urandom_range(0, 15) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
